// File: rtl/gbc_dma_pkg.sv
// Shared definitions for the Game Boy Color DMA engines: FSM encoding and
// the OAM / register map constants.
package gbc_dma_pkg;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StStart = 2'd1,
    StRead  = 2'd2,
    StWrite = 2'd3
  } dma_state_e;

  localparam logic [15:0] OAM_BASE = 16'hFE00;
  localparam logic [15:0] DMA_REG  = 16'hFF46;
  localparam int unsigned OAM_LEN  = 160;
  // First page of the echo-RAM window that mirrors 0xC000-0xDDFF.
  localparam logic [7:0]  ECHO_LO  = 8'hE0;

endpackage

// File: rtl/oam_dma_if.sv
// CPU register port and memory-bus control signals of the OAM DMA engine.
// master: the DMA engine; slave: CPU/arbiter/memory side.
interface oam_dma_if;

  logic        reg_we;
  logic [15:0] reg_addr;
  logic [7:0]  reg_wdata;
  logic [7:0]  reg_rdata;
  logic        bus_grant;
  logic        dma_active;
  logic [15:0] addr_ext;
  logic        mem_re;
  logic        mem_we;

  modport master (
    input  reg_we,
    input  reg_addr,
    input  reg_wdata,
    output reg_rdata,
    input  bus_grant,
    output dma_active,
    output addr_ext,
    output mem_re,
    output mem_we
  );

  modport slave (
    output reg_we,
    output reg_addr,
    output reg_wdata,
    input  reg_rdata,
    output bus_grant,
    input  dma_active,
    input  addr_ext,
    input  mem_re,
    input  mem_we
  );

endinterface

// File: rtl/oam_dma.sv
// OAM DMA: copies LENGTH bytes from {page,8'h00} to DST_BASE, two cycles per byte.
// Optional macro OAM_DMA_RESTART_EN: a trigger while busy restarts with the new page.
module oam_dma
  import gbc_dma_pkg::*;
#(
  parameter int unsigned LENGTH   = OAM_LEN,
  parameter logic [15:0] DST_BASE = OAM_BASE,
  parameter logic [15:0] REG_ADDR = DMA_REG
) (
  input  logic      clock,
  input  logic      reset,
  oam_dma_if.master bus,
  inout  wire [7:0] data_ext
);

  localparam logic [7:0] LastIdx = 8'(LENGTH - 1);

  dma_state_e  state_q, state_d;
  logic [7:0]  idx_q, idx_d;
  logic [7:0]  page_q, page_d;
  logic [7:0]  rdata_q, rdata_d;
  logic [7:0]  latch_q, latch_d;

  logic        trigger;
  logic [7:0]  page_eff;
  logic [15:0] src_addr;
  logic [15:0] dst_addr;

  logic        dma_active;
  logic        mem_re;
  logic        mem_we;
  logic [15:0] addr_ext;

  assign trigger  = bus.reg_we && (bus.reg_addr == REG_ADDR);
  // Echo RAM pages fold back onto work RAM.
  assign page_eff = (page_q >= ECHO_LO) ? (page_q - 8'h20) : page_q;
  assign src_addr = {page_eff, idx_q};
  assign dst_addr = DST_BASE + {8'h00, idx_q};

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    page_d     = page_q;
    latch_d    = latch_q;
    rdata_d    = trigger ? bus.reg_wdata : rdata_q;
    dma_active = 1'b0;
    mem_re     = 1'b0;
    mem_we     = 1'b0;
    addr_ext   = 16'h0000;

    unique case (state_q)
      StIdle: begin
        if (trigger) begin
          state_d = StStart;
          idx_d   = 8'h00;
          page_d  = bus.reg_wdata;
        end
      end
      StStart: begin
        dma_active = 1'b1;
        if (bus.bus_grant) state_d = StRead;
      end
      StRead: begin
        dma_active = 1'b1;
        if (bus.bus_grant) begin
          addr_ext = src_addr;
          mem_re   = 1'b1;
          latch_d  = data_ext;
          state_d  = StWrite;
        end
      end
      StWrite: begin
        dma_active = 1'b1;
        if (bus.bus_grant) begin
          addr_ext = dst_addr;
          mem_we   = 1'b1;
          if (idx_q == LastIdx) begin
            state_d = StIdle;
          end else begin
            idx_d   = idx_q + 8'h01;
            state_d = StRead;
          end
        end
      end
      default: state_d = StIdle;
    endcase

`ifdef OAM_DMA_RESTART_EN
    // Bus outputs above are left alone, so a WRITE this cycle still lands.
    if (trigger && (state_q != StIdle)) begin
      idx_d   = 8'h00;
      page_d  = bus.reg_wdata;
      state_d = bus.bus_grant ? StRead : StStart;
    end
`endif
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= StIdle;
      idx_q   <= 8'h00;
      page_q  <= 8'h00;
      rdata_q <= 8'h00;
      latch_q <= 8'h00;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      page_q  <= page_d;
      rdata_q <= rdata_d;
      latch_q <= latch_d;
    end
  end

  assign bus.dma_active = dma_active;
  assign bus.mem_re     = mem_re;
  assign bus.mem_we     = mem_we;
  assign bus.addr_ext   = addr_ext;
  assign bus.reg_rdata  = rdata_q;
  assign data_ext       = mem_we ? latch_q : 8'bz;

endmodule
